// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for six motor drivers: one command at a time,
// direction setup delay, then N symmetric step pulses with optional abort.
module step_pulse_gen #(
  parameter int HALF_PERIOD = 50,
  parameter int DIR_SETUP   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] PulseNum,
  input  logic       Enable,
  input  logic [2:0] Motor,
  input  logic [5:0] DRs,
  input  logic       Stop,
  output logic [5:0] PULs,
  output logic [5:0] DIRs,
  output logic       Busy,
  output logic       Done,
  output logic       Aborted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // The timer counts down to zero, so a phase of L cycles loads L-1.
  localparam logic [15:0] SETUP_LOAD = 16'(DIR_SETUP - 1);
  localparam logic [15:0] HALF_LOAD  = 16'(HALF_PERIOD - 1);

  function automatic logic [5:0] motor_onehot(input logic [2:0] m);
    logic [5:0] oh;
    case (m)
      3'd0:    oh = 6'b000001;
      3'd1:    oh = 6'b000010;
      3'd2:    oh = 6'b000100;
      3'd3:    oh = 6'b001000;
      3'd4:    oh = 6'b010000;
      3'd5:    oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] timer_r, timer_s;
  logic [9:0]  count_r, count_s;
  logic [2:0]  motor_r, motor_s;
  logic [5:0]  dirs_r, dirs_s;
  logic [5:0]  puls_r;
  logic        busy_r, done_r, aborted_r;
  logic        abort_s;
  logic        accept_s;

  assign accept_s = Enable && (PulseNum != 10'd0) && (Motor <= 3'd5);

  // Next-state, phase timer, pulse count and latched command decode.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    count_s = count_r;
    motor_s = motor_r;
    dirs_s  = dirs_r;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SETUP;
          timer_s = SETUP_LOAD;
          count_s = PulseNum;
          motor_s = Motor;
          for (int i = 0; i < 6; i++) begin
            if (Motor == i[2:0]) begin
              dirs_s[i] = DRs[i];
            end else begin
              dirs_s[i] = dirs_r[i];
            end
          end
        end else begin
          timer_s = 16'd0;
        end
      end
      SETUP: begin
        if (Stop) begin
          state_s = DONE;
          timer_s = 16'd0;
          abort_s = 1'b1;
        end else if (timer_r == 16'd0) begin
          state_s = HIGH;
          timer_s = HALF_LOAD;
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      HIGH: begin
        if (Stop) begin
          state_s = DONE;
          timer_s = 16'd0;
          abort_s = 1'b1;
        end else if (timer_r == 16'd0) begin
          state_s = LOW;
          timer_s = HALF_LOAD;
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      LOW: begin
        // An abort wins over the end of the phase, so a cut pulse is never counted.
        if (Stop) begin
          state_s = DONE;
          timer_s = 16'd0;
          abort_s = 1'b1;
        end else if (timer_r == 16'd0) begin
          count_s = count_r - 10'd1;
          if (count_r == 10'd1) begin
            state_s = DONE;
            timer_s = 16'd0;
          end else begin
            state_s = HIGH;
            timer_s = HALF_LOAD;
          end
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        timer_s = 16'd0;
      end
      default: begin
        state_s = IDLE;
        timer_s = 16'd0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= 16'd0;
      count_r <= 10'd0;
      motor_r <= 3'd0;
      dirs_r  <= 6'b000000;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      count_r <= count_s;
      motor_r <= motor_s;
      dirs_r  <= dirs_s;
    end
  end

  // Output flops are loaded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      puls_r    <= 6'b000000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      puls_r    <= (state_s == HIGH) ? motor_onehot(motor_s) : 6'b000000;
      busy_r    <= (state_s != IDLE);
      done_r    <= (state_s == DONE);
      aborted_r <= abort_s;
    end
  end

  assign PULs    = puls_r;
  assign DIRs    = dirs_r;
  assign Busy    = busy_r;
  assign Done    = done_r;
  assign Aborted = aborted_r;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed self-checking bench for step_pulse_gen with HALF_PERIOD=4, DIR_SETUP=3.
module tb_step_pulse_gen;

  logic       clk;
  logic       rst;
  logic [9:0] PulseNum;
  logic       Enable;
  logic [2:0] Motor;
  logic [5:0] DRs;
  logic       Stop;
  logic [5:0] PULs;
  logic [5:0] DIRs;
  logic       Busy;
  logic       Done;
  logic       Aborted;

  int errors = 0;
  int checks = 0;

  step_pulse_gen #(.HALF_PERIOD(4), .DIR_SETUP(3)) dut (
    .clk(clk), .rst(rst), .PulseNum(PulseNum), .Enable(Enable), .Motor(Motor),
    .DRs(DRs), .Stop(Stop), .PULs(PULs), .DIRs(DIRs), .Busy(Busy), .Done(Done),
    .Aborted(Aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected PULs k cycles after acceptance: 3 setup cycles, then 4 high / 4 low per pulse.
  function automatic logic [31:0] pul_exp(input int k, input int n, input logic [31:0] val);
    if (k >= 3 && k < 3 + 8 * n && ((k - 3) % 8) < 4) return val;
    else return 32'd0;
  endfunction

  initial begin
    int rises;
    int hi;
    int dn;
    int done_k;
    logic prev;

    rst = 1'b1; Enable = 1'b0; PulseNum = 10'd0; Motor = 3'd0; DRs = 6'b000000; Stop = 1'b0;
    tick(); tick();
    chk("rst_puls", 32'(PULs), 32'd0);
    chk("rst_dirs", 32'(DIRs), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_abrt", 32'(Aborted), 32'd0);
    rst = 1'b0;
    tick();

    // Basic run: 3 pulses on motor 2, reverse direction
    PulseNum = 10'd3; Motor = 3'd2; DRs = 6'b000100; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    chk("basic_dirs0", 32'(DIRs), 32'h04);
    chk("basic_busy0", 32'(Busy), 32'd1);
    chk("basic_puls0", 32'(PULs), 32'd0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("basic_puls", 32'(PULs), pul_exp(k, 3, 32'h04));
      chk("basic_done", 32'(Done), (k == 27) ? 32'd1 : 32'd0);
      chk("basic_busy", 32'(Busy), (k <= 27) ? 32'd1 : 32'd0);
    end

    // Ignored requests: zero count, then motor out of range
    PulseNum = 10'd0; Motor = 3'd1; DRs = 6'b111111; Enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("ign0_busy", 32'(Busy), 32'd0);
      chk("ign0_puls", 32'(PULs), 32'd0);
      chk("ign0_dirs", 32'(DIRs), 32'h04);
    end
    PulseNum = 10'd5; Motor = 3'd6;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("ign6_busy", 32'(Busy), 32'd0);
      chk("ign6_puls", 32'(PULs), 32'd0);
      chk("ign6_dirs", 32'(DIRs), 32'h04);
    end
    Enable = 1'b0;

    // Abort during the second high phase of a 5-pulse command
    PulseNum = 10'd5; Motor = 3'd0; DRs = 6'b000000; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    rises = 0; prev = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (PULs[0] && !prev) rises++;
      prev = PULs[0];
    end
    chk("abort_inhigh", 32'(PULs), 32'h01);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    chk("abort_puls", 32'(PULs), 32'd0);
    chk("abort_done", 32'(Done), 32'd1);
    chk("abort_abrt", 32'(Aborted), 32'd1);
    chk("abort_rises", 32'(rises), 32'd2);
    tick();
    chk("abort_done1", 32'(Done), 32'd0);
    chk("abort_abrt1", 32'(Aborted), 32'd0);
    chk("abort_busy1", 32'(Busy), 32'd0);
    chk("abort_dirs", 32'(DIRs), 32'h04);

    // Busy lockout: a different request held for the whole command
    PulseNum = 10'd2; Motor = 3'd1; DRs = 6'b000010; Enable = 1'b1;
    tick();
    PulseNum = 10'd1; Motor = 3'd3; DRs = 6'b001000;
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("lock_puls", 32'(PULs), pul_exp(k, 2, 32'h02));
      chk("lock_done", 32'(Done), (k == 19) ? 32'd1 : 32'd0);
      chk("lock_busy", 32'(Busy), (k <= 19 || k == 21) ? 32'd1 : 32'd0);
    end
    Enable = 1'b0;
    chk("lock_dirs", 32'(DIRs), 32'h0E);
    hi = 0; dn = 0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (PULs == 6'b001000) hi++;
      if (Done) dn++;
    end
    chk("lock2_high", 32'(hi), 32'd4);
    chk("lock2_done", 32'(dn), 32'd1);
    chk("lock2_busy", 32'(Busy), 32'd0);

    // Stop together with Enable in IDLE: accepted, then aborts from SETUP
    PulseNum = 10'd4; Motor = 3'd3; DRs = 6'b000000; Enable = 1'b1; Stop = 1'b1;
    tick();
    Enable = 1'b0;
    chk("stpen_busy", 32'(Busy), 32'd1);
    chk("stpen_done0", 32'(Done), 32'd0);
    chk("stpen_dirs", 32'(DIRs), 32'h06);
    tick();
    Stop = 1'b0;
    chk("stpen_done", 32'(Done), 32'd1);
    chk("stpen_abrt", 32'(Aborted), 32'd1);
    chk("stpen_puls", 32'(PULs), 32'd0);
    tick();
    chk("stpen_busy1", 32'(Busy), 32'd0);

    // Reset asserted between clock edges while motor 0 is stepping
    PulseNum = 10'd2; Motor = 3'd0; DRs = 6'b000001; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("rmid_high", 32'(PULs), 32'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_puls", 32'(PULs), 32'd0);
    chk("rmid_dirs", 32'(DIRs), 32'd0);
    chk("rmid_busy", 32'(Busy), 32'd0);
    chk("rmid_done", 32'(Done), 32'd0);
    chk("rmid_abrt", 32'(Aborted), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rmid_idle", 32'(Busy), 32'd0);
    PulseNum = 10'd1; Motor = 3'd5; DRs = 6'b100000; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    chk("rel_dirs", 32'(DIRs), 32'h20);
    chk("rel_busy", 32'(Busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("rel_puls", 32'(PULs), pul_exp(k, 1, 32'h20));
      chk("rel_done", 32'(Done), (k == 11) ? 32'd1 : 32'd0);
    end

    // Maximum count: 1023 pulses on motor 4
    PulseNum = 10'd1023; Motor = 3'd4; DRs = 6'b000000; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    rises = 0; prev = 1'b0; done_k = -1;
    for (int k = 1; k <= 9000 && done_k < 0; k++) begin
      tick();
      if (PULs[4] && !prev) rises++;
      prev = PULs[4];
      if (Done) done_k = k;
    end
    chk("max_rises", 32'(rises), 32'd1023);
    chk("max_donek", 32'(done_k), 32'd8187);
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (PULs != 6'b000000) hi++;
    end
    chk("max_extra", 32'(hi), 32'd0);
    chk("max_busy", 32'(Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
